// File: rtl/dispense_cmd_initiator.sv
// dispense_cmd_initiator: initiator end of the four-phase dispense command link (flag up, ack up, flag down, ack down)
// Ports:
//   clk          system clock
//   rstn         synchronous active-low reset
//   start        request pulse, accepted only in IDLE while abort is low
//   amount_i     requested amount, 11 is rejected as invalid
//   abort        cancels any transaction in flight
//   handshake_i  asynchronous ack from the responder, 2-flop synchronised
//   amount_o     latched amount lines to the responder
//   candyflag_o  dispense request flag to the responder
//   busy         high outside IDLE
//   done         one-cycle pulse on successful completion
//   err          one-cycle pulse on failure
//   err_code     00 abort, 01 ack timeout, 10 release timeout, 11 invalid amount
// Optional feature: DISP_RETRY_EN retries once after the first WAIT_ACK timeout
module dispense_cmd_initiator #(
   parameter int SETUP_CYC   = 16,
   parameter int TIMEOUT_CYC = 50_000_000,
   parameter int CNT_W       = 32
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic [1:0] amount_i,
   input  logic       abort,
   input  logic       handshake_i,
   output logic [1:0] amount_o,
   output logic       candyflag_o,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);
   typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, WAIT_REL} state_t;
   localparam logic [CNT_W-1:0] S_END = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] T_END = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   state_t           state;
   logic             s1, hs;
   logic [CNT_W-1:0] cnt, scnt;
`ifdef DISP_RETRY_EN
   logic             retried;
`endif
   function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + ONE;
   endfunction
   // scnt times a stale ack in SETUP separately, since cnt is held at 0 while hs is high
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         s1          <= 1'b0;
         hs          <= 1'b0;
         cnt         <= '0;
         scnt        <= '0;
         amount_o    <= 2'b00;
         candyflag_o <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= 2'b00;
`ifdef DISP_RETRY_EN
         retried     <= 1'b0;
`endif
      end else begin
         s1   <= handshake_i;
         hs   <= s1;
         done <= 1'b0;
         err  <= 1'b0;
         if (abort && state != IDLE) begin
            candyflag_o <= 1'b0;
            err         <= 1'b1;
            err_code    <= 2'b00;
            busy        <= 1'b0;
            state       <= IDLE;
         end else begin
            case (state)
               IDLE: begin
`ifdef DISP_RETRY_EN
                  retried <= 1'b0;
`endif
                  if (start && !abort) begin
                     if (amount_i == 2'b11) begin
                        err      <= 1'b1;
                        err_code <= 2'b11;
                     end else begin
                        amount_o <= amount_i;
                        cnt      <= '0;
                        scnt     <= '0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                     end
                  end
               end
               SETUP: begin
                  candyflag_o <= 1'b0;
                  if (hs) begin
                     cnt <= '0;
                     if (scnt == T_END) begin
                        err      <= 1'b1;
                        err_code <= 2'b01;
                        busy     <= 1'b0;
                        state    <= IDLE;
                     end else
                        scnt <= sat(scnt);
                  end else begin
                     scnt <= '0;
                     if (cnt == S_END) begin
                        candyflag_o <= 1'b1;
                        cnt         <= '0;
                        state       <= WAIT_ACK;
                     end else
                        cnt <= sat(cnt);
                  end
               end
               WAIT_ACK: begin
                  if (hs) begin
                     candyflag_o <= 1'b0;
                     cnt         <= '0;
                     state       <= WAIT_REL;
                  end else if (cnt == T_END) begin
                     candyflag_o <= 1'b0;
                     cnt         <= '0;
`ifdef DISP_RETRY_EN
                     if (!retried) begin
                        retried <= 1'b1;
                        scnt    <= '0;
                        state   <= SETUP;
                     end else begin
                        err      <= 1'b1;
                        err_code <= 2'b01;
                        busy     <= 1'b0;
                        state    <= IDLE;
                     end
`else
                     err      <= 1'b1;
                     err_code <= 2'b01;
                     busy     <= 1'b0;
                     state    <= IDLE;
`endif
                  end else
                     cnt <= sat(cnt);
               end
               WAIT_REL: begin
                  candyflag_o <= 1'b0;
                  if (!hs) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else if (cnt == T_END) begin
                     err      <= 1'b1;
                     err_code <= 2'b10;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end else
                     cnt <= sat(cnt);
               end
            endcase
         end
      end
   end
endmodule
